// File: rtl/interrupt_controller_if.sv
// Bus between the exception block/CPU side and the interrupt controller.
// The master drives interrupt lines, mask writes and ack/eret; the slave reports request and status.
interface interrupt_controller_if;
   logic [3:0] IRQ;
   logic       IntMaskWe;
   logic [3:0] IntMaskData;
   logic       IntAck;
   logic       ERET;
   logic       NMI;
   logic [1:0] NMI_ID;
   logic [3:0] IntMask;
   logic [3:0] IntPending;
   logic       InService;
   logic [1:0] ServiceID;

   modport master (
      output IRQ, IntMaskWe, IntMaskData, IntAck, ERET,
      input  NMI, NMI_ID, IntMask, IntPending, InService, ServiceID
   );

   modport slave (
      input  IRQ, IntMaskWe, IntMaskData, IntAck, ERET,
      output NMI, NMI_ID, IntMask, IntPending, InService, ServiceID
   );
endinterface

// File: rtl/interrupt_controller.sv
// Four-source edge-triggered, fixed-priority interrupt controller with one request in flight
// and a post-ERET hold-off before the next request is raised.
module interrupt_controller #(
   parameter int HOLDOFF   = 4,
   parameter int HOLDOFF_W = 4
) (
   input logic                   clk,
   input logic                   reset,
   interrupt_controller_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE, S_HOLDOFF} state_t;

   state_t               state, state_next;
   logic [3:0]           irq_d;
   logic [3:0]           pending, pending_next;
   logic [3:0]           mask, mask_next;
   logic                 nmi, nmi_next;
   logic [1:0]           nmi_id, nmi_id_next;
   logic                 in_service, in_service_next;
   logic [1:0]           service_id, service_id_next;
   logic [HOLDOFF_W-1:0] cnt, cnt_next;
   logic [3:0]           eligible;
   logic [3:0]           clr;
   logic [1:0]           win_id;
   logic                 win_any;

   assign eligible = pending & mask;

   always_comb begin
      win_id  = '0;
      win_any = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (eligible[i] && !win_any) begin
            win_id  = 2'(i);
            win_any = 1'b1;
         end
      end
   end

   always_comb begin
      state_next      = state;
      nmi_next        = nmi;
      nmi_id_next     = nmi_id;
      in_service_next = in_service;
      service_id_next = service_id;
      cnt_next        = cnt;
      clr             = '0;
      unique case (state)
         S_IDLE: begin
            if (win_any) begin
               state_next  = S_REQ;
               nmi_next    = 1'b1;
               nmi_id_next = win_id;
            end
         end
         S_REQ: begin
            if (bus.IntAck) begin
               state_next      = S_SERVICE;
               nmi_next        = 1'b0;
               in_service_next = 1'b1;
               service_id_next = nmi_id;
               clr[nmi_id]     = 1'b1;
            end
         end
         S_SERVICE: begin
            if (bus.ERET) begin
               in_service_next = 1'b0;
               if (HOLDOFF == 0) begin
                  state_next = S_IDLE;
               end else begin
                  state_next = S_HOLDOFF;
                  cnt_next   = HOLDOFF_W'(HOLDOFF - 1);
               end
            end
         end
         S_HOLDOFF: begin
            if (cnt == '0) state_next = S_IDLE;
            else           cnt_next   = cnt - 1'b1;
         end
         default: state_next = S_IDLE;
      endcase
      // A fresh edge on the bit being acknowledged is a new request, so set beats clear.
      pending_next = (pending & ~clr) | (bus.IRQ & ~irq_d);
      mask_next    = bus.IntMaskWe ? bus.IntMaskData : mask;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         irq_d      <= '0;
         pending    <= '0;
         mask       <= '0;
         nmi        <= 1'b0;
         nmi_id     <= '0;
         in_service <= 1'b0;
         service_id <= '0;
         cnt        <= '0;
      end else begin
         state      <= state_next;
         irq_d      <= bus.IRQ;
         pending    <= pending_next;
         mask       <= mask_next;
         nmi        <= nmi_next;
         nmi_id     <= nmi_id_next;
         in_service <= in_service_next;
         service_id <= service_id_next;
         cnt        <= cnt_next;
      end
   end

   assign bus.NMI        = nmi;
   assign bus.NMI_ID     = nmi_id;
   assign bus.IntMask    = mask;
   assign bus.IntPending = pending;
   assign bus.InService  = in_service;
   assign bus.ServiceID  = service_id;

endmodule
